// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - MIPS 5-stage control: decode, ID/EX/MEM/WB control pipe, hazards, forwarding
module pipe_control_unit #(
  parameter int OP_W   = 6,
  parameter int REG_W  = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             valid_id,
  input  logic [OP_W-1:0]  op_id,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             br_cond_ex,
  output logic             ext_op_id,
  output logic             jump_id,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             reg_dst_ex,
  output logic             alu_src_ex,
  output logic [REG_W-1:0] rs_ex,
  output logic [REG_W-1:0] rt_ex,
  output logic             branch_taken_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_write_mem,
  output logic             mem_read_mem,
  output logic             reg_write_wb,
  output logic             mem_to_reg_wb,
  output logic [REG_W-1:0] wreg_wb
);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  typedef struct packed {
    logic             valid;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             beq;
    logic             bne;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] wreg;
  } idex_t;

  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] wreg;
  } memwb_t;

  idex_t  idex_q, idex_d, dec;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic r_type, is_lw, is_sw, is_beq, is_bne, is_j, is_addi, is_logi, known, uses_rt;
  logic ex_hit, mem_hit, load_use, raw_stall, taken_raw, stall;
  logic mem_fw, wb_fw;

  always_comb begin
    r_type  = (op_id == OP_RTYPE);
    is_lw   = (op_id == OP_LW);
    is_sw   = (op_id == OP_SW);
    is_beq  = (op_id == OP_BEQ);
    is_bne  = (op_id == OP_BNE);
    is_j    = (op_id == OP_J);
    is_addi = (op_id == OP_ADDI);
    is_logi = (op_id == OP_ANDI) | (op_id == OP_ORI) | (op_id == OP_XORI);
    known   = r_type | is_lw | is_sw | is_beq | is_bne | is_j | is_addi | is_logi;
    uses_rt = r_type | is_sw | is_beq | is_bne;
    ext_op_id = known & ~is_logi;
    dec = '0;
    if (valid_id) begin
      dec.valid      = 1'b1;
      dec.reg_dst    = r_type;
      dec.alu_src    = known & ~(r_type | is_beq | is_bne);
      dec.mem_read   = is_lw;
      dec.mem_write  = is_sw;
      dec.mem_to_reg = is_lw;
      dec.beq        = is_beq;
      dec.bne        = is_bne;
      dec.rs         = rs_id;
      dec.rt         = rt_id;
      dec.wreg       = r_type ? rd_id : rt_id;
      dec.reg_write  = (r_type | is_lw | is_addi | is_logi) & (dec.wreg != '0);
    end
  end

  // Writes to r0 never create a dependency.
  always_comb begin
    ex_hit    = (idex_q.wreg != '0) &
                ((idex_q.wreg == rs_id) | (uses_rt & (idex_q.wreg == rt_id)));
    mem_hit   = (exmem_q.wreg != '0) &
                ((exmem_q.wreg == rs_id) | (uses_rt & (exmem_q.wreg == rt_id)));
    load_use  = valid_id & idex_q.valid & idex_q.mem_read & ex_hit;
    raw_stall = 1'b0;
    if (!FWD_EN) begin
      raw_stall = valid_id & ((idex_q.valid & idex_q.reg_write & ex_hit) |
                              (exmem_q.valid & exmem_q.reg_write & mem_hit));
    end
    taken_raw = idex_q.valid & ((idex_q.beq & br_cond_ex) | (idex_q.bne & ~br_cond_ex));
  end

  always_comb begin
    branch_taken_ex = 1'b0;
    stall           = 1'b0;
    jump_id         = 1'b0;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    if (rst) begin
      pc_write = 1'b1;
    end else if (hold_i) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      branch_taken_ex = taken_raw;
      stall           = ~taken_raw & (load_use | raw_stall);
      jump_id         = ~taken_raw & ~stall & valid_id & is_j;
      pc_write        = ~stall;
      ifid_write      = ~stall;
      ifid_flush      = taken_raw | jump_id;
    end
  end

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!hold_i) begin
      idex_d             = (branch_taken_ex | stall) ? '0 : dec;
      exmem_d.valid      = idex_q.valid;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.wreg       = idex_q.wreg;
      memwb_d.valid      = exmem_q.valid;
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      memwb_d.wreg       = exmem_q.wreg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // MEM result is newer than WB, so it wins when both match.
  always_comb begin
    mem_fw = exmem_q.valid & exmem_q.reg_write & (exmem_q.wreg != '0);
    wb_fw  = memwb_q.valid & memwb_q.reg_write & (memwb_q.wreg != '0);
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    if (FWD_EN) begin
      if (mem_fw & (exmem_q.wreg == idex_q.rs))     fwd_a = 2'b10;
      else if (wb_fw & (memwb_q.wreg == idex_q.rs)) fwd_a = 2'b01;
      if (mem_fw & (exmem_q.wreg == idex_q.rt))     fwd_b = 2'b10;
      else if (wb_fw & (memwb_q.wreg == idex_q.rt)) fwd_b = 2'b01;
    end
  end

  assign reg_dst_ex    = idex_q.reg_dst;
  assign alu_src_ex    = idex_q.alu_src;
  assign rs_ex         = idex_q.rs;
  assign rt_ex         = idex_q.rt;
  assign mem_write_mem = exmem_q.mem_write;
  assign mem_read_mem  = exmem_q.mem_read;
  assign reg_write_wb  = memwb_q.reg_write;
  assign mem_to_reg_wb = memwb_q.mem_to_reg;
  assign wreg_wb       = memwb_q.wreg;
endmodule
